mdu_sequencer: RTL and testbench

- Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the execute stage. Handles MULT/MULTU/DIV/DIVU over 32 iterations and owns the HI/LO architectural registers.
- Raises busy so the pipeline stalls MFHI/MFLO and any new mult/div until the result is committed.
- Radix-2 iterative algorithm: shift-add for multiply, restoring division for divide.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/mdu_iter_step.sv | 48 ++++
 rtl/mdu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mdu_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   mdu_op_t    : operation encoding carried on the 'op' port.
//   mdu_state_t : sequencer FSM states.
//   MDU_WIDTH / MDU_ITERS : default datapath width and iteration count.
package cpu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITERS = MDU_WIDTH;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

  // Signed variants are the even encodings.
  function automatic logic op_is_signed(input mdu_op_t o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_t o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// Combinational single radix-2 iteration of the multiply/divide datapath.
//   is_div          : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc, aux        : current {acc,aux} pair
//                     multiply: {product high, product low / remaining multiplier}
//                     divide  : {remainder, quotient / remaining dividend}
//   operand         : multiplicand (multiply) or divisor (divide) magnitude
//   acc_next, aux_next : pair after this iteration
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] aux,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] aux_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] quot_shift;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the multiplier
    // LSB is set; the carry of that add becomes the new MSB after the shift.
    sum = {1'b0, acc} + (aux[0] ? {1'b0, operand} : '0);

    // Divide: {rem,quot} shifted left one bit. The shifted remainder needs
    // WIDTH+1 bits before the trial subtract.
    rem_shift  = {acc, aux[WIDTH-1]};
    quot_shift = {aux[WIDTH-2:0], 1'b0};
    fits       = (rem_shift >= {1'b0, operand});
    // When the subtract fits, the true difference is below the divisor, so the
    // low WIDTH bits of a modulo-2^WIDTH subtract are exact.
    diff       = rem_shift[WIDTH-1:0] - operand;

    if (is_div) begin
      acc_next = fits ? diff : rem_shift[WIDTH-1:0];
      aux_next = quot_shift | {{(WIDTH-1){1'b0}}, fits};
    end else begin
      acc_next = sum[WIDTH:1];
      aux_next = {sum[0], aux[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
//   clk, rst         : clock, synchronous active-high reset
//   start, op        : operation request and encoding (sampled in IDLE/DONE)
//   op_src_1/2       : multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we     : MTHI/MTLO strobes with wdata (ignored while busy)
//   busy             : operation in flight (RUN or FIX)
//   done             : one-cycle pulse, hi/lo hold the new result
//   div_by_zero      : pulses with done for a divide by zero
//   hi, lo           : architectural HI/LO registers
//
// Handshake: start is a request with no ready wire; it is taken on any edge
// where the unit is in IDLE or DONE (busy==0) and dropped silently otherwise.
// done is the single-cycle completion indication; there is no back-pressure.
module mdu_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_src_1,
  input  logic [WIDTH-1:0] op_src_2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  mdu_state_t state_q, state_d;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, aux, operand;
  logic             is_div_q, neg_res_q, neg_rem_q, dbz_q;

  mdu_op_t          op_e;
  logic             accept_ready, accept, div_zero;
  logic             sign_1, sign_2;
  logic [WIDTH-1:0] mag_1, mag_2;
  logic [WIDTH-1:0] acc_next, aux_next;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc),
    .aux      (aux),
    .operand  (operand),
    .acc_next (acc_next),
    .aux_next (aux_next)
  );

  // Operand decode: signed ops work on two's-complement magnitudes held as
  // unsigned WIDTH bits, so the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    op_e   = mdu_op_t'(op);
    sign_1 = op_is_signed(op_e) & op_src_1[WIDTH-1];
    sign_2 = op_is_signed(op_e) & op_src_2[WIDTH-1];
    mag_1  = sign_1 ? (~op_src_1 + 1'b1) : op_src_1;
    mag_2  = sign_2 ? (~op_src_2 + 1'b1) : op_src_2;
    div_zero = op_is_div(op_e) && (op_src_2 == '0);
  end

  // Sign correction applied in FIX, committed to hi/lo on the edge into DONE.
  always_comb begin
    prod_fix = neg_res_q ? (~{acc, aux} + 1'b1) : {acc, aux};
    quot_fix = neg_res_q ? (~aux + 1'b1) : aux;
    rem_fix  = neg_rem_q ? (~acc + 1'b1) : acc;
  end

  // Next-state and outputs.
  always_comb begin
    state_d      = state_q;
    accept_ready = 1'b0;
    accept       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    div_by_zero  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        accept_ready = 1'b1;
        done         = (state_q == ST_DONE);
        div_by_zero  = (state_q == ST_DONE) && dbz_q;
        if (start) begin
          accept  = 1'b1;
          state_d = div_zero ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == '0) state_d = ST_FIX;
      end
      ST_FIX: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and HI/LO. Later assignments in this block take priority, which
  // lets a result overwrite an MTHI/MTLO issued on the same accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      aux       <= '0;
      operand   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      dbz_q <= accept && div_zero;

      if (accept_ready && hi_we) hi <= wdata;
      if (accept_ready && lo_we) lo <= wdata;

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            is_div_q  <= op_is_div(op_e);
            neg_res_q <= sign_1 ^ sign_2;
            neg_rem_q <= sign_1;
            cnt       <= CW'(ITERS - 1);
            acc       <= '0;
            if (op_is_div(op_e)) begin
              aux     <= mag_1;
              operand <= mag_2;
            end else begin
              aux     <= mag_2;
              operand <= mag_1;
            end
            // Divide by zero completes immediately with a fixed result.
            if (div_zero) begin
              hi <= op_src_1;
              lo <= '1;
            end
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          aux <= aux_next;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        ST_FIX: begin
          if (is_div_q) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int W = 32;
  localparam int DONE_CYC = 34;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_1, src_2, wdata;
  logic         hi_we, lo_we;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_sequencer #(.WIDTH(W), .ITERS(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .op_src_1    (src_1),
    .op_src_2    (src_2),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard: expected results queued by each test, popped at completion.
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drivers assume they are called at a negedge. launch leaves the bench at
  // the negedge of cycle 1 (start sampled at edge 0).
  task automatic launch(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    op    = o;
    src_1 = a;
    src_2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from_cyc, output int cyc, output int nbusy);
    cyc   = from_cyc;
    nbusy = 0;
    while (!done && cyc < 200) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_result(input string tag, input int cyc, input int exp_cyc, input logic exp_dbz);
    logic [2*W-1:0] e;
    e = exp_q.pop_front();
    check({tag, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, "_hi"}, 64'(hi), 64'(e[2*W-1:W]));
    check({tag, "_lo"}, 64'(lo), 64'(e[W-1:0]));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  // Full normal op: launch, wait, compare against queued {hi,lo}.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int cyc, nb;
    exp_q.push_back({ehi, elo});
    launch(o, a, b);
    wait_done(1, cyc, nb);
    check_result(tag, cyc, DONE_CYC, 1'b0);
    @(negedge clk);
  endtask

  int cyc, nb, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; src_1 = '0; src_2 = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk);

    // MULTU all-ones squared, with latency/busy profile
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy_c1", 64'(busy), 64'd1);
    wait_done(1, cyc, nb);
    check("multu_busy_cycles", 64'(nb), 64'd33);
    check("multu_busy_at_done", 64'(busy), 64'd0);
    check_result("multu_ff", cyc, DONE_CYC, 1'b0);
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);

    run_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_min_dm1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

    // Divide by zero completes in cycle 1
    exp_q.push_back({32'd7, 32'hFFFF_FFFF});
    launch(2'b11, 32'd7, 32'd0);
    wait_done(1, cyc, nb);
    check_result("divu_by0", cyc, 1, 1'b1);
    @(negedge clk);
    check("by0_dbz_clear", 64'(div_by_zero), 64'd0);

    // MTLO in IDLE
    lo_we = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", 64'(lo), 64'h1234);
    check("mtlo_hi_kept", 64'(hi), 64'd7);

    // MULTU 2x3 with a second start and an MTLO at cycle 10: both ignored
    exp_q.push_back({32'd0, 32'd6});
    launch(2'b01, 32'd2, 32'd3);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; src_1 = 32'd50; src_2 = 32'd5;
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    check("busy_mtlo_ignored", 64'(lo), 64'h1234);
    wait_done(10, cyc, nb);
    check_result("multu_2x3", cyc, DONE_CYC, 1'b0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_queued_op", 64'(ndone), 64'd0);

    // Reset in the middle of a MULT
    launch(2'b00, 32'd1000, 32'hFFFF_FFF0);
    repeat (13) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_op("divu_9d3", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3);

    // MTHI on the accepting edge is written, then overwritten by the result
    exp_q.push_back({32'd0, 32'd20});
    hi_we = 1'b1; wdata = 32'hABCD;
    launch(2'b01, 32'd4, 32'd5);
    hi_we = 1'b0;
    check("mthi_with_start", 64'(hi), 64'hABCD);
    wait_done(1, cyc, nb);
    check_result("multu_4x5", cyc, DONE_CYC, 1'b0);

    // Back-to-back start accepted in DONE
    exp_q.push_back({32'd2, 32'd3});
    launch(2'b11, 32'd20, 32'd6);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(1, cyc, nb);
    check_result("divu_20d6", cyc, DONE_CYC, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
